// File: rtl/audio_rx_i2s.sv
// I2S receiver: oversampled BCLK/LRCLK/SD deserializer feeding a FWFT frame FIFO.
// Define AUDIO_RX_OVF_CNT_EN to add the saturating dropped-frame counter port.
module audio_rx_i2s #(
  parameter int pSamplingBitWidth = 16,
  parameter int pFifoDepthBit     = 4
) (
  input  logic                             iAudioClk,
  input  logic                             iAudioRst,
  input  logic                             iAudioRxEn,
  input  logic                             iAudioBclk,
  input  logic                             iAudioLrclk,
  input  logic                             iAudioSd,
  output logic [2*pSamplingBitWidth-1:0]   oAudioRxData,
  output logic                             oAudioRxVd,
  input  logic                             iAudioRxRdy,
  output logic [pFifoDepthBit:0]           oAudioRxCnt,
  output logic                             oAudioRxFull,
  output logic                             oAudioRxOvf,
`ifdef AUDIO_RX_OVF_CNT_EN
  output logic [15:0]                      oAudioRxOvfCnt,
`endif
  input  logic                             iAudioRxOvfClr
);

  localparam int W     = pSamplingBitWidth;
  localparam int DEPTH = 1 << pFifoDepthBit;
  localparam int CW    = $clog2(W + 1);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [W-1:0]  MSB  = {1'b1, {(W-1){1'b0}}};
  localparam logic [pFifoDepthBit:0] FULLV = (pFifoDepthBit+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE, SKIP} state_t;

  logic bclk_s1, bclk_s2, bclk_s3;
  logic lr_s1, lr_s2, sd_s1, sd_s2;
  logic bclk_rise, lr_last;
  logic smp_vld, smp_lr, smp_sd, smp_bnd;

  state_t state, state_nx;
  logic cap_bit, word_done, start_word, clr;
  logic [CW-1:0] cnt;
  logic ch, have_left, push_q;
  logic [W-1:0] left_word, right_word;
  logic [W-1:0] mask, base, wr_word;

  logic [2*W-1:0] mem [DEPTH];
  logic [pFifoDepthBit:0] wptr, rptr, fill;
  logic full, vd, pop, push_ok, ovf_set;

  always_ff @(posedge iAudioClk or posedge iAudioRst) begin
    if (iAudioRst) begin
      bclk_s1 <= 1'b0;
      bclk_s2 <= 1'b0;
      bclk_s3 <= 1'b0;
      lr_s1   <= 1'b0;
      lr_s2   <= 1'b0;
      sd_s1   <= 1'b0;
      sd_s2   <= 1'b0;
    end else begin
      bclk_s1 <= iAudioBclk;
      bclk_s2 <= bclk_s1;
      bclk_s3 <= bclk_s2;
      lr_s1   <= iAudioLrclk;
      lr_s2   <= lr_s1;
      sd_s1   <= iAudioSd;
      sd_s2   <= sd_s1;
    end
  end

  assign bclk_rise = bclk_s2 & ~bclk_s3;

  // One registered sample per BCLK rise, tagged with LRCLK-change boundary
  always_ff @(posedge iAudioClk or posedge iAudioRst) begin
    if (iAudioRst) begin
      smp_vld <= 1'b0;
      smp_lr  <= 1'b0;
      smp_sd  <= 1'b0;
      smp_bnd <= 1'b0;
      lr_last <= 1'b0;
    end else begin
      smp_vld <= bclk_rise;
      if (bclk_rise) begin
        smp_lr  <= lr_s2;
        smp_sd  <= sd_s2;
        smp_bnd <= lr_s2 ^ lr_last;
        lr_last <= lr_s2;
      end
    end
  end

  always_ff @(posedge iAudioClk or posedge iAudioRst) begin
    if (iAudioRst) state <= IDLE;
    else           state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (!iAudioRxEn) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nx = SYNC;
        SYNC:    if (smp_vld & smp_bnd & ~smp_lr) state_nx = CAPTURE;
        CAPTURE: begin
          if (smp_vld & ~smp_bnd & (cnt == LAST)) state_nx = SKIP;
        end
        SKIP:    if (smp_vld & smp_bnd) state_nx = CAPTURE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    cap_bit    = 1'b0;
    word_done  = 1'b0;
    start_word = 1'b0;
    clr        = 1'b0;
    if (!iAudioRxEn || state == IDLE) begin
      clr = 1'b1;
    end else begin
      unique case (state)
        SYNC:    start_word = smp_vld & smp_bnd & ~smp_lr;
        CAPTURE: begin
          cap_bit    = smp_vld;
          word_done  = smp_vld & (smp_bnd | (cnt == LAST));
          start_word = smp_vld & smp_bnd;
        end
        SKIP:    start_word = smp_vld & smp_bnd;
        default: ;
      endcase
    end
  end

  // First bit of a word clears it, so short slots come out zero-filled
  always_comb begin
    mask    = MSB >> cnt;
    base    = (cnt == '0) ? '0 : (ch ? right_word : left_word);
    wr_word = smp_sd ? (base | mask) : (base & ~mask);
  end

  always_ff @(posedge iAudioClk or posedge iAudioRst) begin
    if (iAudioRst) begin
      cnt        <= '0;
      ch         <= 1'b0;
      have_left  <= 1'b0;
      left_word  <= '0;
      right_word <= '0;
      push_q     <= 1'b0;
    end else begin
      push_q <= word_done & ch & have_left;
      if (clr) begin
        cnt       <= '0;
        ch        <= 1'b0;
        have_left <= 1'b0;
      end else begin
        if (cap_bit) begin
          cnt <= cnt + 1'b1;
          if (ch) right_word <= wr_word;
          else    left_word  <= wr_word;
        end
        if (word_done) have_left <= ~ch;
        if (start_word) begin
          ch  <= smp_lr;
          cnt <= '0;
        end
      end
    end
  end

  assign fill    = wptr - rptr;
  assign vd      = (fill != '0);
  assign full    = (fill == FULLV);
  assign pop     = vd & iAudioRxRdy;
  assign push_ok = push_q & (~full | pop);
  assign ovf_set = push_q & full & ~pop;

  always_ff @(posedge iAudioClk) begin
    if (push_ok) mem[wptr[pFifoDepthBit-1:0]] <= {left_word, right_word};
  end

  always_ff @(posedge iAudioClk or posedge iAudioRst) begin
    if (iAudioRst) begin
      wptr        <= '0;
      rptr        <= '0;
      oAudioRxOvf <= 1'b0;
    end else begin
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      if (ovf_set)             oAudioRxOvf <= 1'b1;
      else if (iAudioRxOvfClr) oAudioRxOvf <= 1'b0;
    end
  end

`ifdef AUDIO_RX_OVF_CNT_EN
  always_ff @(posedge iAudioClk or posedge iAudioRst) begin
    if (iAudioRst) begin
      oAudioRxOvfCnt <= '0;
    end else if (iAudioRxOvfClr) begin
      oAudioRxOvfCnt <= {15'd0, ovf_set};
    end else if (ovf_set && oAudioRxOvfCnt != 16'hFFFF) begin
      oAudioRxOvfCnt <= oAudioRxOvfCnt + 16'd1;
    end
  end
`endif

  assign oAudioRxData = vd ? mem[rptr[pFifoDepthBit-1:0]] : '0;
  assign oAudioRxVd   = vd;
  assign oAudioRxCnt  = fill;
  assign oAudioRxFull = full;

endmodule

// File: tb/tb_audio_rx_i2s.sv
// Directed bench for audio_rx_i2s: I2S frames driven at BCLK = clk/8,
// FIFO contents, flags and latency compared against hand-computed values.
module tb_audio_rx_i2s;

  localparam int W = 16;

  logic        clk, rst, en, bclk, lrclk, sd, rdy, ovf_clr;
  logic [31:0] data;
  logic        vd, full, ovf;
  logic [4:0]  cnt;
`ifdef AUDIO_RX_OVF_CNT_EN
  logic [15:0] ovf_cnt;
`endif

  int   checks = 0;
  int   passed = 0;
  int   lat;
  logic dly_bit;

  audio_rx_i2s dut (
    .iAudioClk      (clk),
    .iAudioRst      (rst),
    .iAudioRxEn     (en),
    .iAudioBclk     (bclk),
    .iAudioLrclk    (lrclk),
    .iAudioSd       (sd),
    .oAudioRxData   (data),
    .oAudioRxVd     (vd),
    .iAudioRxRdy    (rdy),
    .oAudioRxCnt    (cnt),
    .oAudioRxFull   (full),
    .oAudioRxOvf    (ovf),
`ifdef AUDIO_RX_OVF_CNT_EN
    .oAudioRxOvfCnt (ovf_cnt),
`endif
    .iAudioRxOvfClr (ovf_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // md: 0 plain, 1 measure Vd latency, 2 pop on push cycle, 3 clear on push cycle
  task automatic send_period(input logic l, input logic d, input int md);
    @(negedge clk);
    bclk = 1'b0;
    lrclk = l;
    sd = dly_bit;
    dly_bit = d;
    repeat (4) @(negedge clk);
    bclk = 1'b1;
    if (md == 0) begin
      repeat (3) @(negedge clk);
    end else begin
      for (int k = 1; k <= 8; k++) begin
        @(negedge clk);
        if (md == 1 && lat < 0 && vd) lat = k;
        if (md == 2) rdy = (k == 4);
        if (md == 3) ovf_clr = (k == 4);
      end
    end
  endtask

  task automatic send_slot(input logic [31:0] w, input int s, input logic l,
                           input int md);
    for (int p = 0; p < s; p++)
      send_period(l, w[s-1-p], (l && p == W) ? md : 0);
  endtask

  task automatic send_frame(input logic [31:0] l, input logic [31:0] r,
                            input int s, input int md);
    send_slot(l, s, 1'b0, 0);
    send_slot(r, s, 1'b1, md);
  endtask

  task automatic restart();
    @(negedge clk);
    en = 1'b0;
    rdy = 1'b0;
    send_period(1'b0, 1'b0, 0);
    send_period(1'b0, 1'b0, 0);
    en = 1'b1;
  endtask

  task automatic pop(output logic [31:0] d, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (vd) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    d = data;
    rdy = 1'b1;
    @(negedge clk);
    rdy = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++; if (vd !== 1'b0) $display("FAIL rst_vd got %b want 0", vd); else passed++;
    checks++; if (cnt !== 5'd0) $display("FAIL rst_cnt got %0d want 0", cnt); else passed++;
    checks++; if (data !== 32'h0) $display("FAIL rst_data got %h want 0", data); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL rst_ovf got %b want 0", ovf); else passed++;
    checks++; if (full !== 1'b0) $display("FAIL rst_full got %b want 0", full); else passed++;
`ifdef AUDIO_RX_OVF_CNT_EN
    checks++; if (ovf_cnt !== 16'd0) $display("FAIL rst_ovfcnt got %0d want 0", ovf_cnt); else passed++;
`endif
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic ok;
    restart();
    send_frame(32'h0, 32'h0, 32, 0);
    lat = -1;
    send_frame(32'hA5A5_0000, 32'h5A5A_0000, 32, 1);
    send_frame(32'hA5A5_0000, 32'h5A5A_0000, 32, 0);
    send_frame(32'hA5A5_0000, 32'h5A5A_0000, 32, 0);
    checks++; if (lat !== 5) $display("FAIL basic_latency got %0d want 5", lat); else passed++;
    checks++; if (cnt !== 5'd3) $display("FAIL basic_cnt got %0d want 3", cnt); else passed++;
    for (int i = 0; i < 3; i++) begin
      pop(d, ok);
      checks++;
      if (!ok || d !== 32'hA5A55A5A) $display("FAIL basic_pop%0d got %h want a5a55a5a", i, d);
      else passed++;
    end
  endtask

  task automatic test_slots();
    logic [31:0] d;
    logic ok;
    restart();
    send_frame(32'h0, 32'h0, 8, 0);
    send_frame(32'hAB, 32'hCD, 8, 0);
    send_period(1'b0, 1'b0, 0);
    repeat (8) @(negedge clk);
    checks++; if (cnt !== 5'd1) $display("FAIL short_cnt got %0d want 1", cnt); else passed++;
    pop(d, ok);
    checks++;
    if (!ok || d !== 32'hAB00CD00) $display("FAIL short_data got %h want ab00cd00", d);
    else passed++;
    restart();
    send_frame(32'h0, 32'h0, 24, 0);
    send_frame(32'h123456, 32'h654321, 24, 0);
    pop(d, ok);
    checks++;
    if (!ok || d !== 32'h12346543) $display("FAIL long_data got %h want 12346543", d);
    else passed++;
  endtask

  task automatic test_disable();
    logic [31:0] d;
    logic ok;
    restart();
    send_frame(32'h0, 32'h0, 32, 0);
    for (int p = 0; p < 6; p++) send_period(1'b0, 1'b1, 0);
    en = 1'b0;
    repeat (100) @(negedge clk);
    en = 1'b1;
    for (int p = 6; p < 32; p++) send_period(1'b0, 1'b1, 0);
    send_slot(32'hFFFF_FFFF, 32, 1'b1, 0);
    repeat (8) @(negedge clk);
    checks++; if (cnt !== 5'd0) $display("FAIL dis_nopush got %0d want 0", cnt); else passed++;
    send_frame(32'h1357_0000, 32'h2468_0000, 32, 0);
    pop(d, ok);
    checks++;
    if (!ok || d !== 32'h13572468) $display("FAIL dis_resume got %h want 13572468", d);
    else passed++;
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    logic ok;
    logic [15:0] nv;
    restart();
    send_frame(32'h0, 32'h0, 16, 0);
    for (int n = 1; n <= 17; n++) begin
      nv = 16'(n);
      send_frame({16'h0, nv}, {16'h0, ~nv}, 16, 0);
    end
    send_period(1'b0, 1'b0, 0);
    repeat (8) @(negedge clk);
    checks++; if (cnt !== 5'd16) $display("FAIL ovf_cnt16 got %0d want 16", cnt); else passed++;
    checks++; if (full !== 1'b1) $display("FAIL ovf_full got %b want 1", full); else passed++;
    checks++; if (ovf !== 1'b1) $display("FAIL ovf_flag got %b want 1", ovf); else passed++;
`ifdef AUDIO_RX_OVF_CNT_EN
    checks++; if (ovf_cnt !== 16'd1) $display("FAIL ovf_count got %0d want 1", ovf_cnt); else passed++;
`endif
    for (int n = 1; n <= 16; n++) begin
      nv = 16'(n);
      pop(d, ok);
      checks++;
      if (!ok || d !== {nv, ~nv}) $display("FAIL ovf_pop%0d got %h want %h", n, d, {nv, ~nv});
      else passed++;
    end
    checks++; if (vd !== 1'b0) $display("FAIL ovf_drained got %b want 0", vd); else passed++;
    @(negedge clk);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) $display("FAIL ovf_clear got %b want 0", ovf); else passed++;
  endtask

  task automatic test_full_pop();
    logic [31:0] d;
    logic ok;
    logic [15:0] nv;
    restart();
    send_frame(32'h0, 32'h0, 32, 0);
    for (int n = 1; n <= 16; n++) begin
      nv = 16'(n);
      send_frame({nv, 16'h0}, {~nv, 16'h0}, 32, 0);
    end
    checks++; if (full !== 1'b1) $display("FAIL fp_full got %b want 1", full); else passed++;
    send_frame({16'd17, 16'h0}, {~16'd17, 16'h0}, 32, 2);
    checks++; if (cnt !== 5'd16) $display("FAIL fp_cnt got %0d want 16", cnt); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL fp_noovf got %b want 0", ovf); else passed++;
    send_frame({16'd18, 16'h0}, {~16'd18, 16'h0}, 32, 3);
    checks++; if (ovf !== 1'b1) $display("FAIL fp_setwins got %b want 1", ovf); else passed++;
    checks++; if (cnt !== 5'd16) $display("FAIL fp_cnt2 got %0d want 16", cnt); else passed++;
`ifdef AUDIO_RX_OVF_CNT_EN
    checks++; if (ovf_cnt !== 16'd1) $display("FAIL fp_ovfcnt got %0d want 1", ovf_cnt); else passed++;
`endif
    for (int n = 2; n <= 17; n++) begin
      nv = 16'(n);
      pop(d, ok);
      checks++;
      if (!ok || d !== {nv, ~nv}) $display("FAIL fp_pop%0d got %h want %h", n, d, {nv, ~nv});
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic ok;
    restart();
    send_frame(32'h0, 32'h0, 32, 0);
    for (int i = 0; i < 3; i++) send_frame(32'h1111_0000, 32'h2222_0000, 32, 0);
    checks++; if (cnt !== 5'd3) $display("FAIL rm_pre got %0d want 3", cnt); else passed++;
    for (int p = 0; p < 10; p++) send_period(1'b0, 1'b1, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (vd !== 1'b0) $display("FAIL rm_vd got %b want 0", vd); else passed++;
    checks++; if (cnt !== 5'd0) $display("FAIL rm_cnt got %0d want 0", cnt); else passed++;
    checks++; if (data !== 32'h0) $display("FAIL rm_data got %h want 0", data); else passed++;
    checks++; if (ovf !== 1'b0) $display("FAIL rm_ovf got %b want 0", ovf); else passed++;
`ifdef AUDIO_RX_OVF_CNT_EN
    checks++; if (ovf_cnt !== 16'd0) $display("FAIL rm_ovfcnt got %0d want 0", ovf_cnt); else passed++;
`endif
    rst = 1'b0;
    for (int p = 10; p < 32; p++) send_period(1'b0, 1'b1, 0);
    send_slot(32'hFFFF_FFFF, 32, 1'b1, 0);
    repeat (8) @(negedge clk);
    checks++; if (cnt !== 5'd0) $display("FAIL rm_nopush got %0d want 0", cnt); else passed++;
    send_frame(32'h7777_0000, 32'h8888_0000, 32, 0);
    pop(d, ok);
    checks++;
    if (!ok || d !== 32'h77778888) $display("FAIL rm_resume got %h want 77778888", d);
    else passed++;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    bclk = 1'b0;
    lrclk = 1'b0;
    sd = 1'b0;
    rdy = 1'b0;
    ovf_clr = 1'b0;
    dly_bit = 1'b0;
    lat = -1;
    test_reset();
    test_basic();
    test_slots();
    test_disable();
    test_overflow();
    test_full_pop();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
